// File: rtl/seg7_scroll_if.sv
// Pin-side bundle for the scrolling 7-segment sequencer.
// Blank exists only when SEG7_BLANK_EN is defined.
interface seg7_scroll_if;
  logic       Run;
  logic       Step;
  logic       Dir;
`ifdef SEG7_BLANK_EN
  logic       Blank;
`endif
  logic [6:0] SEG7;
  logic [3:0] AN;
  logic [1:0] S;
  logic       FrameTick;

  modport master (
`ifdef SEG7_BLANK_EN
    output Blank,
`endif
    output Run, Step, Dir,
    input  SEG7, AN, S, FrameTick
  );

  modport slave (
`ifdef SEG7_BLANK_EN
    input  Blank,
`endif
    input  Run, Step, Dir,
    output SEG7, AN, S, FrameTick
  );
endinterface

// File: rtl/seg7_scroll_ctrl.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned rotation of "dE10".
// Optional SEG7_BLANK_EN adds a Blank input that darkens the display.
module seg7_scroll_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 50000000
) (
  input logic          Clock,
  input logic          Resetn,
  seg7_scroll_if.slave bus
);

  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int SCW = $clog2(SCROLL_DIV);
  localparam logic [RCW-1:0] RC_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCROLL_DIV - 1);

  typedef enum logic {PAUSE, RUN} state_t;

  state_t         state_reg, state_next;
  logic [RCW-1:0] rc_reg, rc_next;
  logic [SCW-1:0] sc_reg, sc_next;
  logic [1:0]     dig_reg, dig_next;
  logic [1:0]     s_reg, s_next;
  logic           pending_reg, pending_next;
  logic           step_prev_reg;
  logic           frame_tick_reg;
  logic [6:0]     seg_reg, seg_next;
  logic [3:0]     an_reg, an_next;

  logic           rc_wrap;
  logic           frame_wrap;
  logic           scroll_req;
  logic           step_req;
  logic [1:0]     char_code;
  logic [6:0]     seg_pat;
  logic [3:0]     an_dec;

  assign rc_wrap    = (rc_reg == RC_LAST);
  assign frame_wrap = rc_wrap && (dig_reg == 2'd3);
  assign rc_next    = rc_wrap ? '0 : rc_reg + RCW'(1);
  assign dig_next   = rc_wrap ? dig_reg + 2'd1 : dig_reg;
  assign step_req   = (state_reg == PAUSE) && bus.Step && !step_prev_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= PAUSE;
    else         state_reg <= state_next;
  end

  // Any state change restarts the scroll interval.
  always_comb begin
    state_next = state_reg;
    sc_next    = sc_reg;
    scroll_req = 1'b0;
    case (state_reg)
      PAUSE: if (bus.Run)  state_next = RUN;
      RUN: begin
        if (!bus.Run) state_next = PAUSE;
        else if (sc_reg == SC_LAST) scroll_req = 1'b1;
      end
      default: state_next = PAUSE;
    endcase
    if (state_next != state_reg) sc_next = '0;
    else if (state_reg == RUN)   sc_next = scroll_req ? '0 : sc_reg + SCW'(1);
  end

  // A request raised on the boundary cycle itself waits for the next frame.
  always_comb begin
    s_next       = s_reg;
    pending_next = pending_reg;
    if (frame_wrap) begin
      pending_next = 1'b0;
      if (pending_reg) s_next = bus.Dir ? s_reg - 2'd1 : s_reg + 2'd1;
    end
    if (scroll_req || step_req) pending_next = 1'b1;
  end

  assign char_code = dig_reg + s_reg;

  always_comb begin
    seg_pat = 7'h7F;
    case (char_code)
      2'd0: seg_pat = 7'b0100001;
      2'd1: seg_pat = 7'b0000110;
      2'd2: seg_pat = 7'b1111001;
      2'd3: seg_pat = 7'b1000000;
      default: seg_pat = 7'h7F;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_dec[gi] = (dig_reg != 2'(gi));
  end

`ifdef SEG7_BLANK_EN
  assign an_next  = bus.Blank ? 4'hF  : an_dec;
  assign seg_next = bus.Blank ? 7'h7F : seg_pat;
`else
  assign an_next  = an_dec;
  assign seg_next = seg_pat;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rc_reg         <= '0;
      sc_reg         <= '0;
      dig_reg        <= 2'd0;
      s_reg          <= 2'd0;
      pending_reg    <= 1'b0;
      step_prev_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
      seg_reg        <= 7'h7F;
      an_reg         <= 4'hF;
    end else begin
      rc_reg         <= rc_next;
      sc_reg         <= sc_next;
      dig_reg        <= dig_next;
      s_reg          <= s_next;
      pending_reg    <= pending_next;
      step_prev_reg  <= bus.Step;
      frame_tick_reg <= frame_wrap;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
    end
  end

  assign bus.SEG7      = seg_reg;
  assign bus.AN        = an_reg;
  assign bus.S         = s_reg;
  assign bus.FrameTick = frame_tick_reg;

endmodule
